// File: rtl/mem_bus_pkg.sv
// Shared types and memory-map bounds for the CPU-side memory bus master.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  localparam logic [15:0] IO_BASE       = 16'h0010;
  localparam logic [15:0] PERIPH_BASE   = 16'h0100;
  localparam logic [15:0] RAM_BASE      = 16'h0200;
  localparam logic [15:0] UNMAPPED_BASE = 16'h0400;
  localparam logic [15:0] ROM_BASE      = 16'hC000;

  // Hole between the end of RAM and the start of ROM.
  function automatic logic is_unmapped(input logic [15:0] addr);
    return (addr >= UNMAPPED_BASE) && (addr < ROM_BASE);
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Byte-lane steering: read-side byte extract/zero-extend, write-side byte replicate.
module mem_byte_lane (
  input  logic        is_byte,
  input  logic        hi_byte,
  input  logic [15:0] rd_word,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic [15:0] wr_word
);

  always_comb begin
    rd_data = rd_word;
    wr_word = wr_data;
    if (is_byte) begin
      rd_data = {8'h00, (hi_byte ? rd_word[15:8] : rd_word[7:0])};
      wr_word = {wr_data[7:0], wr_data[7:0]};
    end
  end

endmodule

// File: rtl/mem_bus_master.sv
// CPU request to memory bus master (IDLE/READ/WRITE/RESP).
// Optional write timeout enabled by defining MEM_TIMEOUT_EN.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] MAB_out,
  output logic [15:0] MDB_wr,
  output logic        MW,
  output logic        BW,
  input  logic [15:0] MDB_rd,
  input  logic        ram_write_done
);

  state_t      state, state_nxt;
  logic        lat_write, lat_byte;
  logic [15:0] lat_addr, lat_wdata;
  logic [15:0] lane_rdata, lane_wword;
  logic        accept;
  logic        timeout_hit;

  assign accept = req_valid && (state == IDLE);

  mem_byte_lane u_lane (
    .is_byte (lat_byte),
    .hi_byte (lat_addr[0]),
    .rd_word (MDB_rd),
    .wr_data (lat_wdata),
    .rd_data (lane_rdata),
    .wr_word (lane_wword)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               wr_cnt <= '0;
    else if (state != WRITE)  wr_cnt <= '0;
    else                      wr_cnt <= wr_cnt + 1'b1;
  end

  assign timeout_hit = (state == WRITE) && (wr_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (is_unmapped(req_addr)) state_nxt = RESP;
          else if (req_write)        state_nxt = WRITE;
          else                       state_nxt = READ;
        end
      end
      READ:    state_nxt = RESP;
      WRITE:   if (ram_write_done || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_write <= 1'b0;
      lat_byte  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_byte  <= req_byte;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Response fields only change on the edge that enters RESP, so they hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && is_unmapped(req_addr)) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        READ: begin
          rsp_rdata <= lane_rdata;
          rsp_err   <= 1'b0;
        end
        WRITE: begin
          if (ram_write_done) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    MAB_out   = '0;
    MDB_wr    = '0;
    MW        = 1'b0;
    BW        = 1'b0;
    case (state)
      READ: MAB_out = {lat_addr[15:1], 1'b0};
      WRITE: begin
        MW      = lat_write;
        BW      = lat_byte;
        MAB_out = lat_byte ? lat_addr : {lat_addr[15:1], 1'b0};
        MDB_wr  = lane_wword;
      end
      default: ;
    endcase
  end

endmodule
